prf_mp: RTL and testbench
=========================

Name: prf_mp

Overview:
- Parametrised multi-port physical register file with a per-register ready scoreboard, for the out-of-order backend.
- Rename/dispatch allocates destination tags, which clears their ready bits.
- CDB writeback ports write data and set ready bits.
- Issue-stage read ports return operand data and readiness, with same-cycle writeback bypass and an optional registered read stage.

Parameters:
NUM_PREGS, 256, number of physical registers (power of 2, >=4)
TAG_W, 8, tag width, equals log2(NUM_PREGS)
DATA_W, 32, register data width
NUM_RD, 4, number of read ports
NUM_WR, 4, number of writeback (CDB) ports
NUM_ALLOC, 2, number of allocate ports
READ_REG, 1, 0 = combinational read (latency 0), 1 = registered read (latency 1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
alloc_valid  in  NUM_ALLOC  allocate-port valid bits
alloc_tag  in  NUM_ALLOC*TAG_W  tags being allocated, port i at bits [i*TAG_W +: TAG_W]
wr_valid  in  NUM_WR  writeback valid bits
wr_tag  in  NUM_WR*TAG_W  writeback tags
wr_data  in  NUM_WR*DATA_W  writeback data
rd_tag  in  NUM_RD*TAG_W  read tags
rd_data  out  NUM_RD*DATA_W  read data
rd_ready  out  NUM_RD  read operand ready
ready_vec  out  NUM_PREGS  registered ready scoreboard, bit p = preg p ready
wr_conflict  out  1  registered one-cycle pulse: two or more valid wr ports hit the same nonzero tag in the previous cycle

Behaviour:
- Reset (async assert, sync-safe deassert): all data entries 0; ready_vec all 1s; registered rd_data 0 and rd_ready 0 (READ_REG=1); wr_conflict 0. Reset asserted mid-operation discards all in-flight writes and allocations immediately.
- Preg 0 is hardwired: reads return data 0 and ready 1. Writes and allocations to tag 0 are ignored. ready_vec[0] is always 1.
- Writeback at posedge for each valid port: data[wr_tag] <= wr_data, ready[wr_tag] <= 1.
  - Same tag on several valid wr ports: the highest-index port's data is written.
  - wr_conflict = 1 on the following cycle only.
- Allocate at posedge for each valid port: ready[alloc_tag] <= 0. Data is unchanged.
  - Duplicate alloc tags are harmless.
- Alloc and writeback to the same tag in the same cycle: data is written, final ready = 0 (alloc wins).
- Read value per port, tag t != 0:
  - If any valid wr port has wr_tag == t: bypass. Data = highest-index matching wr_data, ready = 1.
  - Else: data = data[t], ready = ready[t].
  - If ready[t] = 0 and there is no bypass: rd_data is still the stale array value and rd_ready = 0. Consumers must qualify rd_data with rd_ready.
- Same-cycle alloc of t does not affect the read result in that cycle (read uses pre-edge ready).
- READ_REG=0: rd_data/rd_ready are combinational from the current-cycle inputs, latency 0.
- READ_REG=1: the read value above is computed from the current-cycle rd_tag/wr_* and registered at posedge, latency 1. rd_tag is sampled at that edge.
- ready_vec reflects state after the last edge. It does not include same-cycle bypass.
- Tags >= NUM_PREGS cannot occur (TAG_W = log2). No out-of-range handling is required.
- Implementation notes:
  - Array: NUM_PREGS x DATA_W flops, reset required.
  - Ready: NUM_PREGS flops.
  - Write decode uses a priority loop, ascending port index, last wins.

Test Plan:
- Reset, then read tags 5 and 0 on ports 0/1 → rd_data 0/0, rd_ready 1/1; ready_vec all 1s.
- Alloc tag 7; next cycle read tag 7 → rd_ready 0, ready_vec[7]=0. Then wr port 2 writes 7 = 0xDEADBEEF. With READ_REG=1, the read issued in the same cycle returns 0xDEADBEEF with ready 1 one cycle later (bypass). The following read from the array returns the same value.
- wr ports 0 and 3 both write tag 9, with 0x11 and 0x33 → data[9] = 0x33, wr_conflict pulses 1 for exactly one cycle. A read of 9 in the write cycle bypasses 0x33.
- Same cycle: alloc tag 12 and wr tag 12 = 0x55 → afterwards ready_vec[12]=0 and a read of 12 returns data 0x55 with rd_ready 0.
- Write tag 0 = 0xFFFF_FFFF and alloc tag 0 → reads of 0 still return 0 with ready 1; ready_vec[0]=1.
- Four writes in flight, assert reset asynchronously mid-cycle → all outputs return to reset values before the next edge. Prior data reads back 0, ready 1.

Source files
------------

// File: rtl/prf_mp.sv
// prf_mp: multi-port physical register file with per-register ready scoreboard.
// Allocation clears ready bits. CDB writeback writes data and sets ready bits.
// Read ports return data and readiness, with same-cycle writeback bypass.
// The read stage is optionally registered.
module prf_mp #(
    parameter int NUM_PREGS = 256,
    parameter int TAG_W     = 8,
    parameter int DATA_W    = 32,
    parameter int NUM_RD    = 4,
    parameter int NUM_WR    = 4,
    parameter int NUM_ALLOC = 2,
    parameter int READ_REG  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_ALLOC-1:0]        alloc_valid,
    input  logic [NUM_ALLOC*TAG_W-1:0]  alloc_tag,
    input  logic [NUM_WR-1:0]           wr_valid,
    input  logic [NUM_WR*TAG_W-1:0]     wr_tag,
    input  logic [NUM_WR*DATA_W-1:0]    wr_data,
    input  logic [NUM_RD*TAG_W-1:0]     rd_tag,
    output logic [NUM_RD*DATA_W-1:0]    rd_data,
    output logic [NUM_RD-1:0]           rd_ready,
    output logic [NUM_PREGS-1:0]        ready_vec,
    output logic                        wr_conflict
);

    // Register array and scoreboard
    logic [DATA_W-1:0]    data_q [NUM_PREGS];
    logic [DATA_W-1:0]    data_d [NUM_PREGS];
    logic [NUM_PREGS-1:0] ready_q;
    logic [NUM_PREGS-1:0] ready_d;
    logic                 conflict_q;
    logic                 conflict_d;

    // Unpacked views of the flat port buses
    logic [TAG_W-1:0]     a_tag [NUM_ALLOC];
    logic [TAG_W-1:0]     w_tag [NUM_WR];
    logic [DATA_W-1:0]    w_dat [NUM_WR];
    logic [TAG_W-1:0]     r_tag [NUM_RD];

    // Combinational read result, before the optional output register
    logic [DATA_W-1:0]    rd_data_c [NUM_RD];
    logic [NUM_RD-1:0]    rd_ready_c;

    // Split the flat input buses into per-port fields
    always_comb begin
        for (int unsigned a = 0; a < NUM_ALLOC; a++) begin
            a_tag[a] = alloc_tag[a*TAG_W +: TAG_W];
        end
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            w_tag[w] = wr_tag[w*TAG_W +: TAG_W];
            w_dat[w] = wr_data[w*DATA_W +: DATA_W];
        end
        for (int unsigned r = 0; r < NUM_RD; r++) begin
            r_tag[r] = rd_tag[r*TAG_W +: TAG_W];
        end
    end

    // Next array/ready state: writebacks in ascending port order (last wins),
    // then allocations override ready so alloc beats a same-cycle writeback.
    always_comb begin
        data_d  = data_q;
        ready_d = ready_q;
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (wr_valid[w] && (w_tag[w] != '0)) begin
                data_d[w_tag[w]]  = w_dat[w];
                ready_d[w_tag[w]] = 1'b1;
            end
        end
        for (int unsigned a = 0; a < NUM_ALLOC; a++) begin
            if (alloc_valid[a] && (a_tag[a] != '0)) begin
                ready_d[a_tag[a]] = 1'b0;
            end
        end
        ready_d[0] = 1'b1;
    end

    // Detect two or more valid writeback ports hitting the same nonzero tag
    always_comb begin
        conflict_d = 1'b0;
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            for (int unsigned j = i + 1; j < NUM_WR; j++) begin
                if (wr_valid[i] && wr_valid[j] && (w_tag[i] == w_tag[j]) &&
                    (w_tag[i] != '0)) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    // Array, scoreboard and conflict flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned p = 0; p < NUM_PREGS; p++) begin
                data_q[p] <= '0;
            end
            ready_q    <= '1;
            conflict_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            ready_q    <= ready_d;
            conflict_q <= conflict_d;
        end
    end

    // Per-port read: array value, overridden by the highest-index matching
    // writeback, and forced to data 0 / ready 1 for preg 0.
    always_comb begin
        for (int unsigned r = 0; r < NUM_RD; r++) begin
            rd_data_c[r]  = data_q[r_tag[r]];
            rd_ready_c[r] = ready_q[r_tag[r]];
            for (int unsigned w = 0; w < NUM_WR; w++) begin
                if (wr_valid[w] && (w_tag[w] == r_tag[r])) begin
                    rd_data_c[r]  = w_dat[w];
                    rd_ready_c[r] = 1'b1;
                end
            end
            if (r_tag[r] == '0) begin
                rd_data_c[r]  = '0;
                rd_ready_c[r] = 1'b1;
            end
        end
    end

    generate
        if (READ_REG != 0) begin : g_rd_reg
            logic [DATA_W-1:0] rd_data_q [NUM_RD];
            logic [NUM_RD-1:0] rd_ready_q;

            // Registered read stage, latency 1
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int unsigned r = 0; r < NUM_RD; r++) begin
                        rd_data_q[r] <= '0;
                    end
                    rd_ready_q <= '0;
                end else begin
                    rd_data_q  <= rd_data_c;
                    rd_ready_q <= rd_ready_c;
                end
            end

            // Pack the registered read results onto the output bus
            always_comb begin
                rd_data = '0;
                for (int unsigned r = 0; r < NUM_RD; r++) begin
                    rd_data[r*DATA_W +: DATA_W] = rd_data_q[r];
                end
                rd_ready = rd_ready_q;
            end
        end else begin : g_rd_comb
            // Combinational read, latency 0
            always_comb begin
                rd_data = '0;
                for (int unsigned r = 0; r < NUM_RD; r++) begin
                    rd_data[r*DATA_W +: DATA_W] = rd_data_c[r];
                end
                rd_ready = rd_ready_c;
            end
        end
    endgenerate

    assign ready_vec   = ready_q;
    assign wr_conflict = conflict_q;

endmodule

// File: tb/tb_prf_mp.sv
// tb_prf_mp: randomized and directed checks of prf_mp (READ_REG=1) against a
// behavioural array/scoreboard model.
module tb_prf_mp;

    localparam int NP = 256;
    localparam int TW = 8;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int NW = 4;
    localparam int NA = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NA-1:0]     alloc_valid;
    logic [NA*TW-1:0]  alloc_tag;
    logic [NW-1:0]     wr_valid;
    logic [NW*TW-1:0]  wr_tag;
    logic [NW*DW-1:0]  wr_data;
    logic [NR*TW-1:0]  rd_tag;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_ready;
    logic [NP-1:0]     ready_vec;
    logic              wr_conflict;

    always #5 clk = ~clk;

    prf_mp #(
        .NUM_PREGS(NP), .TAG_W(TW), .DATA_W(DW), .NUM_RD(NR),
        .NUM_WR(NW), .NUM_ALLOC(NA), .READ_REG(1)
    ) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_tag(alloc_tag),
        .wr_valid(wr_valid), .wr_tag(wr_tag), .wr_data(wr_data),
        .rd_tag(rd_tag), .rd_data(rd_data), .rd_ready(rd_ready),
        .ready_vec(ready_vec), .wr_conflict(wr_conflict)
    );

    // Reference model state
    logic [DW-1:0] m_data [NP];
    logic          m_rdy  [NP];
    // Expected registered outputs after the next edge
    logic [DW-1:0] e_data [NR];
    logic          e_rdy  [NR];
    logic          e_conf;
    logic [NP-1:0] e_vec;

    int checks = 0;
    int errors = 0;

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_data[p] = '0;
            m_rdy[p]  = 1'b1;
        end
    endtask

    task automatic clear_inputs();
        alloc_valid = '0; alloc_tag = '0;
        wr_valid = '0; wr_tag = '0; wr_data = '0;
        rd_tag = '0;
    endtask

    task automatic set_wr(input int port, input int tag, input logic [DW-1:0] d);
        wr_valid[port]          = 1'b1;
        wr_tag[port*TW +: TW]   = tag[TW-1:0];
        wr_data[port*DW +: DW]  = d;
    endtask

    task automatic set_alloc(input int port, input int tag);
        alloc_valid[port]        = 1'b1;
        alloc_tag[port*TW +: TW] = tag[TW-1:0];
    endtask

    task automatic set_rd(input int port, input int tag);
        rd_tag[port*TW +: TW] = tag[TW-1:0];
    endtask

    // Compute expectations from the pre-edge model and current inputs, advance
    // one clock, then commit this cycle's writebacks and allocations.
    task automatic tick();
        int cnt [NP];
        for (int p = 0; p < NP; p++) cnt[p] = 0;
        for (int r = 0; r < NR; r++) begin
            int t;
            t = int'(rd_tag[r*TW +: TW]);
            e_data[r] = m_data[t];
            e_rdy[r]  = m_rdy[t];
            for (int w = NW - 1; w >= 0; w--) begin
                if (wr_valid[w] && int'(wr_tag[w*TW +: TW]) == t) begin
                    e_data[r] = wr_data[w*DW +: DW];
                    e_rdy[r]  = 1'b1;
                    break;
                end
            end
            if (t == 0) begin
                e_data[r] = '0;
                e_rdy[r]  = 1'b1;
            end
        end
        e_conf = 1'b0;
        for (int w = 0; w < NW; w++) begin
            if (wr_valid[w] && wr_tag[w*TW +: TW] != '0)
                cnt[int'(wr_tag[w*TW +: TW])]++;
        end
        for (int p = 0; p < NP; p++) if (cnt[p] >= 2) e_conf = 1'b1;

        @(posedge clk);
        #1;
        for (int w = 0; w < NW; w++) begin
            if (wr_valid[w] && wr_tag[w*TW +: TW] != '0) begin
                m_data[int'(wr_tag[w*TW +: TW])] = wr_data[w*DW +: DW];
                m_rdy[int'(wr_tag[w*TW +: TW])]  = 1'b1;
            end
        end
        for (int a = 0; a < NA; a++) begin
            if (alloc_valid[a] && alloc_tag[a*TW +: TW] != '0)
                m_rdy[int'(alloc_tag[a*TW +: TW])] = 1'b0;
        end
        for (int p = 0; p < NP; p++) e_vec[p] = m_rdy[p];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rd_data !== '0 || rd_ready !== '0) begin
            errors++;
            $display("FAIL reset_rd: got data %h ready %b, expected 0/0", rd_data, rd_ready);
        end
        checks++;
        if (ready_vec !== {NP{1'b1}} || wr_conflict !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got ready_vec %h conflict %b, expected all ones/0",
                     ready_vec, wr_conflict);
        end
        reset = 1'b0;
        set_rd(0, 5);
        set_rd(1, 0);
        tick();
        for (int r = 0; r < 2; r++) begin
            checks++;
            if (rd_data[r*DW +: DW] !== e_data[r] || rd_ready[r] !== e_rdy[r]) begin
                errors++;
                $display("FAIL reset_read port%0d: got %h/%b, expected %h/%b",
                         r, rd_data[r*DW +: DW], rd_ready[r], e_data[r], e_rdy[r]);
            end
        end
        checks++;
        if (ready_vec !== {NP{1'b1}}) begin
            errors++;
            $display("FAIL reset_vec: got %h, expected all ones", ready_vec);
        end
    endtask

    task automatic test_alloc_bypass();
        clear_inputs();
        set_alloc(0, 7);
        set_rd(0, 7);
        tick();
        checks++;
        if (rd_ready[0] !== e_rdy[0]) begin
            errors++;
            $display("FAIL alloc_same_cycle_read: got %b, expected %b", rd_ready[0], e_rdy[0]);
        end
        clear_inputs();
        set_rd(0, 7);
        tick();
        checks++;
        if (rd_ready[0] !== e_rdy[0] || ready_vec !== e_vec) begin
            errors++;
            $display("FAIL alloc_not_ready: got ready %b vec7 %b, expected %b/%b",
                     rd_ready[0], ready_vec[7], e_rdy[0], e_vec[7]);
        end
        clear_inputs();
        set_wr(2, 7, 32'hDEADBEEF);
        set_rd(0, 7);
        tick();
        checks++;
        if (rd_data[0 +: DW] !== e_data[0] || rd_ready[0] !== e_rdy[0]) begin
            errors++;
            $display("FAIL wr_bypass: got %h/%b, expected %h/%b",
                     rd_data[0 +: DW], rd_ready[0], e_data[0], e_rdy[0]);
        end
        clear_inputs();
        set_rd(3, 7);
        tick();
        checks++;
        if (rd_data[3*DW +: DW] !== e_data[3] || rd_ready[3] !== e_rdy[3] ||
            ready_vec !== e_vec) begin
            errors++;
            $display("FAIL array_read: got %h/%b, expected %h/%b",
                     rd_data[3*DW +: DW], rd_ready[3], e_data[3], e_rdy[3]);
        end
    endtask

    task automatic test_conflict();
        clear_inputs();
        set_wr(0, 9, 32'h11);
        set_wr(3, 9, 32'h33);
        set_rd(1, 9);
        tick();
        checks++;
        if (rd_data[DW +: DW] !== e_data[1] || rd_ready[1] !== e_rdy[1]) begin
            errors++;
            $display("FAIL conflict_bypass: got %h/%b, expected %h/%b",
                     rd_data[DW +: DW], rd_ready[1], e_data[1], e_rdy[1]);
        end
        checks++;
        if (wr_conflict !== e_conf) begin
            errors++;
            $display("FAIL conflict_pulse: got %b, expected %b", wr_conflict, e_conf);
        end
        clear_inputs();
        set_rd(1, 9);
        tick();
        checks++;
        if (wr_conflict !== e_conf || rd_data[DW +: DW] !== e_data[1]) begin
            errors++;
            $display("FAIL conflict_after: got conflict %b data %h, expected %b/%h",
                     wr_conflict, rd_data[DW +: DW], e_conf, e_data[1]);
        end
    endtask

    task automatic test_alloc_wr_same();
        clear_inputs();
        set_alloc(1, 12);
        set_wr(1, 12, 32'h55);
        tick();
        clear_inputs();
        set_rd(2, 12);
        tick();
        checks++;
        if (rd_data[2*DW +: DW] !== e_data[2] || rd_ready[2] !== e_rdy[2] ||
            ready_vec !== e_vec) begin
            errors++;
            $display("FAIL alloc_wins: got %h/%b vec12 %b, expected %h/%b/%b",
                     rd_data[2*DW +: DW], rd_ready[2], ready_vec[12],
                     e_data[2], e_rdy[2], e_vec[12]);
        end
    endtask

    task automatic test_tag0();
        clear_inputs();
        set_wr(1, 0, 32'hFFFF_FFFF);
        set_alloc(0, 0);
        set_rd(0, 0);
        tick();
        checks++;
        if (rd_data[0 +: DW] !== e_data[0] || rd_ready[0] !== e_rdy[0]) begin
            errors++;
            $display("FAIL tag0_bypass: got %h/%b, expected %h/%b",
                     rd_data[0 +: DW], rd_ready[0], e_data[0], e_rdy[0]);
        end
        clear_inputs();
        set_rd(2, 0);
        tick();
        checks++;
        if (rd_data[2*DW +: DW] !== e_data[2] || rd_ready[2] !== e_rdy[2] ||
            ready_vec[0] !== 1'b1) begin
            errors++;
            $display("FAIL tag0_array: got %h/%b vec0 %b, expected %h/%b/1",
                     rd_data[2*DW +: DW], rd_ready[2], ready_vec[0], e_data[2], e_rdy[2]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            clear_inputs();
            for (int a = 0; a < NA; a++)
                if ($urandom_range(0, 3) == 0) set_alloc(a, int'($urandom_range(0, 15)));
            for (int w = 0; w < NW; w++)
                if ($urandom_range(0, 1) == 1) set_wr(w, int'($urandom_range(0, 15)), $urandom);
            for (int r = 0; r < NR; r++) set_rd(r, int'($urandom_range(0, 15)));
            tick();
            for (int r = 0; r < NR; r++) begin
                checks++;
                if (rd_data[r*DW +: DW] !== e_data[r] || rd_ready[r] !== e_rdy[r]) begin
                    errors++;
                    $display("FAIL rand_read c%0d port%0d: got %h/%b, expected %h/%b",
                             c, r, rd_data[r*DW +: DW], rd_ready[r], e_data[r], e_rdy[r]);
                end
            end
            checks++;
            if (wr_conflict !== e_conf || ready_vec !== e_vec) begin
                errors++;
                $display("FAIL rand_state c%0d: got conflict %b vec %h, expected %b/%h",
                         c, wr_conflict, ready_vec[15:0], e_conf, e_vec[15:0]);
            end
        end
    endtask

    task automatic test_async_reset();
        clear_inputs();
        set_wr(0, 30, 32'hA5A5_0001);
        set_wr(1, 31, 32'h5A5A_0002);
        set_alloc(0, 50);
        tick();
        clear_inputs();
        set_rd(0, 30);
        set_rd(1, 31);
        set_wr(0, 40, 32'h1);
        set_wr(1, 41, 32'h2);
        set_wr(2, 42, 32'h3);
        set_wr(3, 42, 32'h4);
        set_alloc(1, 43);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (rd_data !== '0 || rd_ready !== '0 || wr_conflict !== 1'b0 ||
            ready_vec !== {NP{1'b1}}) begin
            errors++;
            $display("FAIL async_reset: got data %h ready %b conflict %b vec %h",
                     rd_data, rd_ready, wr_conflict, ready_vec);
        end
        clear_inputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        set_rd(0, 30);
        set_rd(1, 31);
        set_rd(2, 40);
        set_rd(3, 42);
        tick();
        for (int r = 0; r < NR; r++) begin
            checks++;
            if (rd_data[r*DW +: DW] !== e_data[r] || rd_ready[r] !== e_rdy[r]) begin
                errors++;
                $display("FAIL post_reset_read port%0d: got %h/%b, expected %h/%b",
                         r, rd_data[r*DW +: DW], rd_ready[r], e_data[r], e_rdy[r]);
            end
        end
        checks++;
        if (ready_vec !== {NP{1'b1}}) begin
            errors++;
            $display("FAIL post_reset_vec: got %h, expected all ones", ready_vec);
        end
    endtask

    initial begin
        test_reset();
        test_alloc_bypass();
        test_conflict();
        test_alloc_wr_same();
        test_tag0();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
